scoreboard_registros: RTL and testbench

- Register-read-side companion to the 32x32 register file: tracks which architectural registers have writes still in flight, so decode never reads a stale value.
- Decode presents each instruction's source and destination registers. The block grants issue only when no RAW hazard exists and the destination counter has headroom.
- Writeback reports each completed register write and retires one pending write for that register.
- Sits between decode/issue and the writeback path that drives the register file's write port.

---
 rtl/scoreboard_registros.sv | 116 +++++++++++
 tb/tb_scoreboard_registros.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/scoreboard_registros.sv
// Register-write scoreboard: per-register outstanding-write counters that gate
// issue on RAW hazards and counter headroom, retired by writeback.

module scoreboard_registros_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next
);
  always_comb begin
    cnt_next = cnt;
    if (flush)             cnt_next = '0;
    else if (inc && !dec)  cnt_next = cnt + CNT_W'(1);
    else if (dec && !inc)  cnt_next = cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_next;
  end
endmodule

module scoreboard_registros #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wr_rd,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic [31:0]      busy_mask,
  output logic [TOT_W-1:0] pending_total,
  output logic             error
);
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       wr_rd;
  } issue_req_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  issue_req_t             req;
  logic [31:0][CNT_W-1:0] cnt, cnt_next;
  logic [31:1]            inc, dec;
  logic [31:0]            busy_next;
  logic                   raw1, raw2, sat;
  logic                   issue_fire, wb_fire, wb_hit, dec_any;

  assign req = '{rs1: issue_rs1, rs2: issue_rs2, rd: issue_rd,
                 use_rs1: issue_use_rs1, use_rs2: issue_use_rs2, wr_rd: issue_wr_rd};

  // x0 is never tracked: its slot is tied to zero
  assign cnt[0]       = '0;
  assign cnt_next[0]  = '0;
  assign busy_next[0] = 1'b0;

  // Hazards look only at pre-edge counters: no same-cycle writeback bypass
  assign raw1 = req.use_rs1 && (req.rs1 != 5'd0) && (cnt[req.rs1] != '0);
  assign raw2 = req.use_rs2 && (req.rs2 != 5'd0) && (cnt[req.rs2] != '0);
  assign sat  = req.wr_rd   && (req.rd  != 5'd0) && (cnt[req.rd] == CNT_MAX);

  assign issue_ready = reset && !flush && !(raw1 || raw2 || sat);
  assign issue_fire  = issue_valid && issue_ready && req.wr_rd && (req.rd != 5'd0);
  assign wb_fire     = wb_valid && (wb_rd != 5'd0);
  assign wb_hit      = (cnt[wb_rd] != '0);
  assign dec_any     = wb_fire && wb_hit && !flush;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    assign inc[r] = issue_fire && (req.rd == 5'(r));
    assign dec[r] = wb_fire && (wb_rd == 5'(r)) && (cnt[r] != '0);

    scoreboard_registros_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .inc      (inc[r]),
      .dec      (dec[r]),
      .cnt      (cnt[r]),
      .cnt_next (cnt_next[r])
    );

    assign busy_next[r] = |cnt_next[r];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_mask     <= '0;
      pending_total <= '0;
      error         <= 1'b0;
    end else begin
      busy_mask <= busy_next;
      if (flush) pending_total <= '0;
      else       pending_total <= pending_total + TOT_W'(issue_fire) - TOT_W'(dec_any);
      // Stray writeback sticks until reset; flush does not clear it
      if (!flush && wb_fire && !wb_hit) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_scoreboard_registros.sv
// Randomized + directed bench: reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.

module tb_scoreboard_registros;
  logic        clk = 1'b0;
  logic        reset, flush, issue_valid, issue_use_rs1, issue_use_rs2, issue_wr_rd;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        wb_valid, issue_ready, error;
  logic [31:0] busy_mask;
  logic [5:0]  pending_total;

  scoreboard_registros #(.CNT_W(2), .TOT_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_rd(issue_rd), .issue_wr_rd(issue_wr_rd),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_mask(busy_mask), .pending_total(pending_total), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    logic [31:0] busy;
    int          total;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt[32];
  bit   m_err;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("issue_ready",   longint'(issue_ready),   longint'(e.rdy));
      chk("busy_mask",     longint'(busy_mask),     longint'(e.busy));
      chk("pending_total", longint'(pending_total), longint'(e.total % 64));
      chk("error",         longint'(error),         longint'(e.err));
    end
  end

  // One cycle: apply inputs, predict the visible outputs, then advance the model
  task automatic drive(input bit rst_n, input bit fl, input bit v, input bit u1,
                       input bit u2, input bit wr, input bit wbv,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [4:0] wbr);
    exp_t e;
    bit   hazard, fire;
    @(posedge clk);
    #2;
    reset = rst_n; flush = fl; issue_valid = v; issue_use_rs1 = u1;
    issue_use_rs2 = u2; issue_wr_rd = wr; wb_valid = wbv;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; wb_rd = wbr;

    hazard = (u1 && rs1 != 0 && m_cnt[rs1] > 0) ||
             (u2 && rs2 != 0 && m_cnt[rs2] > 0) ||
             (wr && rd != 0 && m_cnt[rd] == 3);
    e.rdy   = rst_n && !fl && !hazard;
    e.busy  = '0;
    e.total = 0;
    for (int i = 1; i < 32; i++) begin
      if (m_cnt[i] > 0) e.busy[i] = 1'b1;
      e.total += m_cnt[i];
    end
    e.err = m_err;
    q.push_back(e);

    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 0;
    end else if (fl) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      fire = v && e.rdy && wr && rd != 0;
      if (wbv && wbr != 0) begin
        if (m_cnt[wbr] > 0) m_cnt[wbr]--;
        else                m_err = 1;
      end
      if (fire) m_cnt[rd]++;
    end
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 0;
    reset = 0; flush = 0; issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
    issue_wr_rd = 0; wb_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; wb_rd = 0;

    // reset held with traffic active
    drive(0, 0, 1, 1, 1, 1, 1, 5, 6, 5, 5);
    drive(0, 0, 1, 1, 1, 1, 1, 5, 6, 5, 5);
    idle();
    // RAW stall, same-cycle writeback does not bypass
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 5, 0);
    drive(1, 0, 1, 1, 0, 0, 1, 5, 0, 0, 5);
    drive(1, 0, 1, 1, 0, 0, 0, 5, 0, 0, 0);
    // x0 never tracked
    repeat (3) drive(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    // WAW saturation on x7
    repeat (4) drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 7, 0);
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0, 7, 7);
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 7, 0);
    idle();
    // simultaneous issue + writeback on x9
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 9, 0);
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0, 9, 9);
    idle();
    // flush, stray writeback, sticky error
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 3, 0);
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 4, 0);
    drive(1, 1, 1, 0, 0, 1, 1, 0, 0, 4, 3);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
    idle();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // x0 writeback must not set error
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();

    // random traffic over a small register window to force hazards
    for (int n = 0; n < 2000; n++) begin
      bit rst_n, fl;
      rst_n = ($urandom_range(0, 199) != 0);
      fl    = ($urandom_range(0, 49) == 0);
      drive(rst_n, fl, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    idle();
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
